// File: rtl/led_mode_if.sv
// Control/status bundle between the LED mode scheduler and its host.
// The mode_mask_i member exists only when LED_MODE_MASK_EN is defined.
interface led_mode_if;
    logic       tick_i;
    logic       btn_next_i;
    logic       btn_freq_i;
    logic       auto_i;
`ifdef LED_MODE_MASK_EN
    logic [3:0] mode_mask_i;
`endif
    logic [1:0] mode_sel_o;
    logic [1:0] freq_sel_o;
    logic [3:0] mode_en_o;
    logic [3:0] mode_rst_o;
    logic       blank_o;
    logic       switch_pulse_o;

    modport master (
`ifdef LED_MODE_MASK_EN
        output mode_mask_i,
`endif
        output tick_i,
        output btn_next_i,
        output btn_freq_i,
        output auto_i,
        input  mode_sel_o,
        input  freq_sel_o,
        input  mode_en_o,
        input  mode_rst_o,
        input  blank_o,
        input  switch_pulse_o
    );

    modport slave (
`ifdef LED_MODE_MASK_EN
        input  mode_mask_i,
`endif
        input  tick_i,
        input  btn_next_i,
        input  btn_freq_i,
        input  auto_i,
        output mode_sel_o,
        output freq_sel_o,
        output mode_en_o,
        output mode_rst_o,
        output blank_o,
        output switch_pulse_o
    );
endinterface

// File: rtl/led_mode_scheduler.sv
// Mode/frequency sequencer for the 4-mode LED pattern subsystem: debounced buttons,
// dwell-based auto-rotation and a blanking interval on every mode change.
// Optional LED_MODE_MASK_EN adds a per-mode enable mask that advance skips over.
module led_mode_scheduler #(
    parameter int unsigned DWELL_TICKS  = 64,
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic      clk,
    input  logic      reset,
    led_mode_if.slave bus
);
    localparam int unsigned DWELL_W  = (DWELL_TICKS  > 1) ? $clog2(DWELL_TICKS)  : 1;
    localparam int unsigned DEB_W    = (DEB_CYCLES   > 1) ? $clog2(DEB_CYCLES)   : 1;
    localparam int unsigned BLANK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned N_BTN    = 2;
    localparam int unsigned BTN_NEXT = 0;
    localparam int unsigned BTN_FREQ = 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [N_BTN-1:0] w_btn_raw;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_deb;
    logic [N_BTN-1:0] r_press;
    logic [DEB_W-1:0] r_deb_cnt [N_BTN];

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BLANK_W-1:0]   r_blank_cnt;
    logic [BLANK_W-1:0]   w_blank_cnt_nxt;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic [1:0]           r_mode_sel;
    logic [1:0]           w_mode_sel_nxt;
    logic [1:0]           w_mode_inc;
    logic [1:0]           r_freq_sel;
    logic [1:0]           w_freq_sel_nxt;
    logic [3:0]           r_mode_en;
    logic [3:0]           w_mode_en_nxt;
    logic [3:0]           r_mode_rst;
    logic [3:0]           w_mode_rst_nxt;
    logic                 r_blank;
    logic                 w_blank_nxt;
    logic                 r_switch_pulse;
    logic                 w_switch_pulse_nxt;
    logic                 w_run_tick;
    logic                 w_expire;

    assign w_btn_raw = {bus.btn_freq_i, bus.btn_next_i};

    // 2-flop synchronizer plus per-button debouncer; r_press is a one-cycle rising event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_press <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < int'(N_BTN); i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb_cnt[i] <= '0;
                    r_deb[i]     <= r_sync2[i];
                    r_press[i]   <= r_sync2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

`ifdef LED_MODE_MASK_EN
    logic [3:0] w_mask_eff;
    logic [1:0] w_cand;
    logic       w_found;

    // First enabled mode after the current one, wrapping; falls back to the current mode
    always_comb begin
        w_mask_eff = (bus.mode_mask_i == 4'b0000) ? 4'b1111 : bus.mode_mask_i;
        w_mode_inc = r_mode_sel;
        w_cand     = r_mode_sel;
        w_found    = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_cand = r_mode_sel + 2'(k);
            if (!w_found && w_mask_eff[w_cand]) begin
                w_mode_inc = w_cand;
                w_found    = 1'b1;
            end
        end
    end
`else
    assign w_mode_inc = r_mode_sel + 2'd1;
`endif

    assign w_run_tick = bus.auto_i & bus.tick_i;
    assign w_expire   = w_run_tick & (r_dwell == DWELL_W'(DWELL_TICKS - 1));

    // Next-state and next-output logic; outputs are registered from the next state
    always_comb begin
        w_state_nxt        = r_state;
        w_blank_cnt_nxt    = r_blank_cnt;
        w_dwell_nxt        = r_dwell;
        w_mode_sel_nxt     = r_mode_sel;
        w_freq_sel_nxt     = r_freq_sel;
        w_switch_pulse_nxt = 1'b0;
        w_mode_en_nxt      = 4'b0000;
        w_mode_rst_nxt     = 4'b1111;
        w_blank_nxt        = 1'b1;

        case (r_state)
            ST_BLANK: begin
                w_dwell_nxt = '0;
                if (r_blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) begin
                    w_blank_cnt_nxt = '0;
                    w_state_nxt     = ST_RUN;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + BLANK_W'(1);
                end
            end
            ST_RUN: begin
                if (r_press[BTN_NEXT] || w_expire) begin
                    w_mode_sel_nxt     = w_mode_inc;
                    w_dwell_nxt        = '0;
                    w_blank_cnt_nxt    = '0;
                    w_switch_pulse_nxt = 1'b1;
                    w_state_nxt        = ST_BLANK;
                end else if (w_run_tick) begin
                    w_dwell_nxt = r_dwell + DWELL_W'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_BLANK;
                w_blank_cnt_nxt = '0;
                w_dwell_nxt     = '0;
            end
        endcase

        if (r_press[BTN_FREQ]) begin
            w_freq_sel_nxt = r_freq_sel + 2'd1;
        end

        if (w_state_nxt == ST_RUN) begin
            w_mode_en_nxt  = 4'b0001 << w_mode_sel_nxt;
            w_mode_rst_nxt = ~w_mode_en_nxt;
            w_blank_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_BLANK;
            r_blank_cnt    <= '0;
            r_dwell        <= '0;
            r_mode_sel     <= 2'd0;
            r_freq_sel     <= 2'd0;
            r_mode_en      <= 4'b0000;
            r_mode_rst     <= 4'b1111;
            r_blank        <= 1'b1;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_blank_cnt    <= w_blank_cnt_nxt;
            r_dwell        <= w_dwell_nxt;
            r_mode_sel     <= w_mode_sel_nxt;
            r_freq_sel     <= w_freq_sel_nxt;
            r_mode_en      <= w_mode_en_nxt;
            r_mode_rst     <= w_mode_rst_nxt;
            r_blank        <= w_blank_nxt;
            r_switch_pulse <= w_switch_pulse_nxt;
        end
    end

    assign bus.mode_sel_o     = r_mode_sel;
    assign bus.freq_sel_o     = r_freq_sel;
    assign bus.mode_en_o      = r_mode_en;
    assign bus.mode_rst_o     = r_mode_rst;
    assign bus.blank_o        = r_blank;
    assign bus.switch_pulse_o = r_switch_pulse;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Scoreboard bench for led_mode_scheduler: stimulus queues expected advances and
// frequency steps; a negedge monitor pops and compares as the DUT reports them.
module tb_led_mode_scheduler;
    localparam int unsigned DWELL = 64;
    localparam int unsigned DEB   = 16;
    localparam int unsigned BLANK = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    led_mode_if bus ();

    led_mode_scheduler #(
        .DWELL_TICKS (DWELL),
        .DEB_CYCLES  (DEB),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        bit         by_dwell;
    } adv_t;

    adv_t       adv_q [$];
    logic [1:0] freq_q[$];
    int checks  = 0;
    int errors  = 0;
    int n_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [1:0] cur_mode, cur_freq, prev_freq, exp_f;
    logic [3:0] exp_en;
    int         blank_len, run_ticks;
    bit         prev_blank, prev_pulse, rst_seen;
    adv_t       e;

    always @(negedge clk) begin
        if (reset) begin
            if (!rst_seen) begin
                check("reset_state",
                      32'({bus.mode_sel_o, bus.freq_sel_o, bus.mode_en_o, bus.mode_rst_o,
                           bus.blank_o, bus.switch_pulse_o}),
                      32'({2'd0, 2'd0, 4'b0000, 4'b1111, 1'b1, 1'b0}));
                rst_seen = 1'b1;
            end
            cur_mode   = 2'd0;
            cur_freq   = 2'd0;
            prev_freq  = 2'd0;
            blank_len  = 0;
            run_ticks  = 0;
            prev_blank = 1'b1;
            prev_pulse = 1'b0;
        end else begin
            rst_seen = 1'b0;
            if (bus.switch_pulse_o) begin
                n_pulse++;
                check("pulse_width", 32'(prev_pulse), 32'd0);
                check("pulse_in_blank", 32'({bus.blank_o, bus.mode_en_o}), 32'(5'b10000));
                if (adv_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_advance actual_mode=%0d expected=none t=%0t",
                             bus.mode_sel_o, $time);
                end else begin
                    e = adv_q.pop_front();
                    check("advance_mode", 32'(bus.mode_sel_o), 32'(e.mode));
                    if (e.by_dwell) check("dwell_ticks", 32'(run_ticks), 32'(DWELL));
                    cur_mode = e.mode;
                end
                run_ticks = 0;
            end
            if (bus.freq_sel_o != prev_freq) begin
                if (freq_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_freq actual=%0d expected=none t=%0t",
                             bus.freq_sel_o, $time);
                end else begin
                    exp_f = freq_q.pop_front();
                    check("freq_value", 32'(bus.freq_sel_o), 32'(exp_f));
                    cur_freq = exp_f;
                end
            end
            prev_freq = bus.freq_sel_o;
            if (bus.blank_o) begin
                blank_len++;
            end else begin
                if (prev_blank) begin
                    exp_en = 4'b0001 << cur_mode;
                    check("blank_len", 32'(blank_len), 32'(BLANK));
                    check("run_outputs",
                          32'({bus.mode_sel_o, bus.freq_sel_o, bus.mode_en_o, bus.mode_rst_o}),
                          32'({cur_mode, cur_freq, exp_en, ~exp_en}));
                end
                blank_len = 0;
                if (bus.tick_i && bus.auto_i) run_ticks++;
            end
            prev_blank = bus.blank_o;
            prev_pulse = bus.switch_pulse_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic exp_adv(input logic [1:0] m, input bit d);
        adv_t a;
        a.mode     = m;
        a.by_dwell = d;
        adv_q.push_back(a);
    endtask

    task automatic exp_freq(input logic [1:0] f);
        freq_q.push_back(f);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk); #1 bus.tick_i = 1'b1;
            @(posedge clk); #1 bus.tick_i = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic press_next();
        @(posedge clk); #1 bus.btn_next_i = 1'b1;
        repeat (22) @(posedge clk);
        #1 bus.btn_next_i = 1'b0;
        idle(40);
    endtask

    task automatic press_freq();
        @(posedge clk); #1 bus.btn_freq_i = 1'b1;
        repeat (22) @(posedge clk);
        #1 bus.btn_freq_i = 1'b0;
        idle(40);
    endtask

    initial begin
        int lat;
        bus.tick_i     = 1'b0;
        bus.btn_next_i = 1'b0;
        bus.btn_freq_i = 1'b0;
        bus.auto_i     = 1'b0;
`ifdef LED_MODE_MASK_EN
        bus.mode_mask_i = 4'b1111;
`endif
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(10);

        // auto-rotation through all four modes
        exp_adv(2'd1, 1'b1);
        exp_adv(2'd2, 1'b1);
        exp_adv(2'd3, 1'b1);
        exp_adv(2'd0, 1'b1);
        bus.auto_i = 1'b1;
        for (int it = 0; it < 2000 && n_pulse < 4; it++) begin
            @(posedge clk); #1 bus.tick_i = 1'b1;
            @(posedge clk); #1 bus.tick_i = 1'b0;
            @(posedge clk);
        end
        check("auto_advances", 32'(n_pulse), 32'd4);
        bus.auto_i = 1'b0;
        idle(10);

        // bouncing next button: one advance, 2 sync + 16 debounce + 1 event cycle later
        exp_adv(2'd1, 1'b0);
        @(posedge clk);
        for (int b = 0; b < 8; b++) begin
            #1 bus.btn_next_i = (b % 2 == 0);
            repeat (5) @(posedge clk);
        end
        #1 bus.btn_next_i = 1'b1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.switch_pulse_o && lat == 0) lat = c;
        end
        check("bounce_latency", 32'(lat), 32'd19);
        bus.btn_next_i = 1'b0;
        idle(40);

        // press event coincides with the 64th tick: single advance
        bus.auto_i = 1'b1;
        exp_adv(2'd2, 1'b1);
        tick_n(63);
        @(posedge clk); #1 bus.btn_next_i = 1'b1;
        repeat (18) @(posedge clk);
        #1 bus.tick_i = 1'b1;
        @(posedge clk); #1 bus.tick_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.btn_next_i = 1'b0;
        idle(40);

        // press event lands inside blanking after a dwell advance: dropped
        exp_adv(2'd3, 1'b1);
        tick_n(63);
        @(posedge clk); #1 bus.btn_next_i = 1'b1;
        repeat (16) @(posedge clk);
        #1 bus.tick_i = 1'b1;
        @(posedge clk); #1 bus.tick_i = 1'b0;
        repeat (7) @(posedge clk);
        #1 bus.btn_next_i = 1'b0;
        bus.auto_i = 1'b0;
        idle(40);

        // frequency stepping, including a step during blanking
        exp_freq(2'd1);
        press_freq();
        exp_freq(2'd2);
        press_freq();
        exp_adv(2'd0, 1'b0);
        exp_freq(2'd3);
        @(posedge clk); #1 bus.btn_next_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.btn_freq_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 bus.btn_next_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.btn_freq_i = 1'b0;
        idle(40);
        exp_freq(2'd0);
        press_freq();

        // reach mode 2 / freq 3 with dwell 30, then reset mid-RUN
        exp_adv(2'd1, 1'b0);
        press_next();
        exp_adv(2'd2, 1'b0);
        press_next();
        exp_freq(2'd1);
        press_freq();
        exp_freq(2'd2);
        press_freq();
        exp_freq(2'd3);
        press_freq();
        bus.auto_i = 1'b1;
        tick_n(30);
        check("queues_before_reset", 32'(adv_q.size() + freq_q.size()), 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bus.auto_i = 1'b0;
        idle(20);

`ifdef LED_MODE_MASK_EN
        bus.mode_mask_i = 4'b0101;
        exp_adv(2'd2, 1'b0);
        press_next();
        exp_adv(2'd0, 1'b0);
        press_next();
`else
        exp_adv(2'd1, 1'b0);
        press_next();
        exp_adv(2'd2, 1'b0);
        press_next();
`endif
        idle(10);
        check("adv_queue_empty", 32'(adv_q.size()), 32'd0);
        check("freq_queue_empty", 32'(freq_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/led_mode_scheduler.md
Name: led_mode_scheduler

Overview:
- Sequencer for the 4-mode LED pattern subsystem.
- Drives mode_sel/freq_sel plus per-mode enables and resets to the four pattern generators and the clock divider.
- Auto-rotation: each mode runs for a programmable number of pattern ticks.
- Manual control: debounced push buttons advance the mode and step the frequency.
- Every mode change passes through a blanking interval, so the incoming pattern always starts from its reset state.

Parameters:
- DWELL_TICKS, 64, tick_i pulses spent in each mode during auto-rotation (≥2).
- DEB_CYCLES, 16, consecutive stable clk cycles needed to accept a button level change (≥2).
- BLANK_CYCLES, 4, clk cycles with all modes held in reset between modes (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- tick_i  input  1  one-clk pattern-step strobe from the divided clock domain, already clk-synchronous.
- btn_next_i  input  1  raw asynchronous "next mode" button, active-high.
- btn_freq_i  input  1  raw asynchronous "next frequency" button, active-high.
- auto_i  input  1  level; 1 = auto-rotate enabled.
- mode_sel_o  output  2  current mode index 0..3.
- freq_sel_o  output  2  divider frequency select 0..3.
- mode_en_o  output  4  one-hot enable to pattern generators.
- mode_rst_o  output  4  per-mode synchronous reset, active-high.
- blank_o  output  1  high during blanking.
- switch_pulse_o  output  1  one-clk pulse on each mode advance.

Behaviour:
- Reset values (async): state=BLANK, blank counter=0, dwell=0, mode_sel_o=0, freq_sel_o=0, mode_en_o=0000, mode_rst_o=1111, blank_o=1, switch_pulse_o=0, debouncer states=0. All outputs are registered.
- Button path:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer counts consecutive cycles where the synced level differs from the debounced level. Any cycle where they match clears the count.
  - At DEB_CYCLES the debounced level flips. A 0→1 flip produces a one-cycle press event.
  - Releases produce no event.
- FSM state BLANK:
  - mode_en_o=0000, mode_rst_o=1111, blank_o=1.
  - The counter increments every clk. After BLANK_CYCLES cycles in BLANK, the FSM goes to RUN, so blank_o is high for exactly BLANK_CYCLES cycles.
  - next-press events in BLANK are dropped.
  - dwell is held at 0.
- FSM state RUN:
  - mode_en_o=one-hot(mode_sel_o), mode_rst_o=~mode_en_o, blank_o=0.
  - If auto_i=1 and tick_i=1, dwell increments.
  - If auto_i=0, dwell holds its value; it is not cleared.
- Advance condition: a next-press event, or (auto_i & tick_i & dwell==DWELL_TICKS-1).
- On advance:
  - mode_sel_o ← mode_sel_o+1 (wraps 3→0), dwell←0, blank counter←0, state←BLANK.
  - switch_pulse_o=1 for the next cycle only.
- Simultaneous press and dwell expiry in the same cycle: a single advance (+1, not +2).
- Frequency: a freq-press event increments freq_sel_o mod 4 (3→0) in any state, independent of the FSM.
- Reset asserted mid-RUN: all state returns to the reset values immediately. After release, the FSM blanks for BLANK_CYCLES cycles and runs mode 0 at freq 0. No switch_pulse_o is generated by reset.
- tick_i outside RUN is ignored.

Optional Feature:
- Macro: LED_MODE_MASK_EN.
- Defined:
  - Adds input port mode_mask_i[3:0]; bit n=1 enables mode n.
  - Advance selects the next enabled index after the current one, searching with wrap.
  - If only the current mode is enabled, mode_sel_o is unchanged, but BLANK and switch_pulse_o still occur.
  - mode_mask_i=0000 is treated as 1111.
  - If the current mode becomes masked during RUN, it keeps running until the next advance.
- Not defined: no port; all four modes visited in order 0,1,2,3,0.

Test Plan:
- Reset release -> blank_o=1 for 4 clks, then mode_en_o=0001, mode_rst_o=1110, mode_sel_o=0, freq_sel_o=0.
- auto_i=1, tick_i every 3 clks, DWELL_TICKS=64 -> after the 64th tick in RUN: switch_pulse_o for 1 clk, 4 blank clks, mode_sel_o=1; after 4 dwell periods mode_sel_o wraps to 0.
- btn_next_i bouncing (toggles every 5 clks for 40 clks, then high 20 clks) -> exactly one advance, event 2+16 clks after the last bounce; release produces no event.
- Press event coincides with 64th tick -> mode_sel_o advances by 1 only. Second press during blanking -> ignored.
- Four btn_freq_i presses -> freq_sel_o 1,2,3,0; mode_sel_o and FSM undisturbed, including presses during BLANK.
- reset pulsed while RUN in mode 2, freq 3, dwell 30 -> mode_sel_o=0, freq_sel_o=0, blank_o=1, no switch_pulse_o. With LED_MODE_MASK_EN and mask=0101, advancing from mode 0 -> mode 2 -> mode 0.
